// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write port plus transmitter status and serial line
interface uart_tx_fifo_if #(parameter int FIFO_DEPTH = 16);
  logic wr_en;
  logic [7:0] wr_data;
  logic full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic overflow;
  logic busy;
  logic tx_out;
  modport master(output wr_en, wr_data, input full, fifo_count, overflow, busy, tx_out);
  modport slave(input wr_en, wr_data, output full, fifo_count, overflow, busy, tx_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N/8E/8O with 1 or 2 stop bits, LSB first
module uart_tx_fifo #(
  parameter int NUM_CYCLES_PER_BIT = 10417,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(NUM_CYCLES_PER_BIT + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic tx_q, tx_d;
  logic busy_q, full_q, ovf_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] head;
  logic push, pop, bit_end;
  assign head = mem[rd_ptr_q];
  assign push = bus.wr_en && !full_q;
  assign pop = (state_q == IDLE) && (cnt_q != '0);
  assign bit_end = timer_q == TW'(NUM_CYCLES_PER_BIT - 1);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE || bit_end) ? '0 : timer_q + TW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    par_d = par_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        shift_d = head;
        par_d = ^head ^ (PARITY_ODD != 0);
        idx_d = '0;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
          idx_d = '0;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // line level follows the state being entered so tx_out stays a plain register
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? shift_d[0] :
           (state_d == PARITY) ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
      busy_q <= (state_d != IDLE) || (cnt_d != '0);
      full_q <= cnt_d == CW'(FIFO_DEPTH);
      ovf_q <= bus.wr_en && full_q;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
    end
  end
  assign bus.tx_out = tx_q;
  assign bus.busy = busy_q;
  assign bus.full = full_q;
  assign bus.overflow = ovf_q;
  assign bus.fifo_count = cnt_q;
endmodule
